// File: rtl/noc_pkg.sv
// Shared NoC link types: router address, flit format and packet header layout.
package noc_pkg;

  localparam int ADDR_W    = 4;
  localparam int HDR_LEN_W = 8;
  localparam int PAYLOAD_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] x;
    logic [ADDR_W-1:0] y;
  } addr_t;

  typedef enum logic [1:0] {
    HEADER = 2'd0,
    BODY   = 2'd1,
    TAIL   = 2'd2
  } flit_type_t;

  typedef struct packed {
    flit_type_t             flit_type;
    logic [PAYLOAD_W-1:0]   payload;
  } flit_t;

  typedef struct packed {
    addr_t                  dst_addr;
    addr_t                  src_addr;
    logic [HDR_LEN_W-1:0]   len;
  } control_hdr_t;

  localparam int FLIT_W = $bits(flit_t);

  function automatic flit_t make_flit(flit_type_t t, logic [PAYLOAD_W-1:0] p);
    flit_t f;
    f.flit_type = t;
    f.payload   = p;
    return f;
  endfunction

endpackage

// File: rtl/flit_out_reg.sv
// Single-slot link output register: holds the flit until acked, reloadable in the
// same cycle the current flit transfers.
module flit_out_reg #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_flit,
  input  logic         ack,
  output logic [W-1:0] flit,
  output logic         enable,
  output logic         free
);

  // free may follow ack combinationally; flit/enable stay purely registered
  assign free = !enable || ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit   <= '0;
      enable <= 1'b0;
    end else if (free) begin
      enable <= load;
      if (load) flit <= load_flit;
    end
  end

endmodule

// File: rtl/ni_packetizer.sv
// NI injection stage: turns a (dst, len) descriptor plus payload words into a
// HEADER / BODY* / TAIL wormhole packet on an enable/ack router link.
//
// state  | meaning
// S_IDLE | waiting for a descriptor; header loaded on handshake
// S_HEAD | zero-length message, tail with empty payload still to be sent
// S_BODY | forwarding payload words, last word goes out as TAIL
module ni_packetizer
  import noc_pkg::*;
#(
  parameter int X     = 1,
  parameter int Y     = 1,
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  addr_t                req_dst,
  input  logic [LEN_W-1:0]     req_len,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic [PAYLOAD_W-1:0] data,
  output flit_t                up_flit,
  output logic                 up_enable,
  input  logic                 up_ack,
  output logic                 busy,
  output logic [CNT_W-1:0]     pkt_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY} state_t;

  state_t           state;
  logic [LEN_W-1:0] rem;
  logic             run;
  logic             slot_free;
  logic             load;
  flit_t            load_flit;
  control_hdr_t     hdr;
  flit_type_t       word_type;
  logic             req_hs;
  logic             data_hs;

  // run keeps req_ready low while reset is held and for the release cycle
  assign req_ready  = run && (state == S_IDLE) && slot_free;
  assign data_ready = (state == S_BODY) && slot_free && (rem != '0);
  assign req_hs     = req_valid && req_ready;
  assign data_hs    = data_valid && data_ready;
  assign busy       = (state != S_IDLE) || up_enable;

  always_comb begin
    hdr.dst_addr   = req_dst;
    hdr.src_addr.x = ADDR_W'(X);
    hdr.src_addr.y = ADDR_W'(Y);
    hdr.len        = HDR_LEN_W'(req_len);
    word_type      = (rem == LEN_W'(1)) ? TAIL : BODY;
    load           = 1'b0;
    load_flit      = '0;
    unique case (state)
      S_IDLE: if (req_hs) begin
        load      = 1'b1;
        load_flit = make_flit(HEADER, PAYLOAD_W'(hdr));
      end
      S_HEAD: if (slot_free) begin
        load      = 1'b1;
        load_flit = make_flit(TAIL, '0);
      end
      S_BODY: if (data_hs) begin
        load      = 1'b1;
        load_flit = make_flit(word_type, data);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      rem   <= '0;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      unique case (state)
        S_IDLE: if (req_hs) begin
          rem   <= req_len;
          state <= (req_len == '0) ? S_HEAD : S_BODY;
        end
        S_HEAD: if (slot_free) state <= S_IDLE;
        S_BODY: if (data_hs) begin
          rem <= rem - LEN_W'(1);
          if (rem == LEN_W'(1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pkt_cnt <= '0;
    else if (up_enable && up_ack && up_flit.flit_type == TAIL) pkt_cnt <= pkt_cnt + CNT_W'(1);
  end

  flit_out_reg #(.W(FLIT_W)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_flit (load_flit),
    .ack       (up_ack),
    .flit      (up_flit),
    .enable    (up_enable),
    .free      (slot_free)
  );

endmodule

// File: tb/tb_ni_packetizer.sv
// Scoreboard bench for ni_packetizer: expected flits queued as stimulus is
// issued, compared as each flit transfers on the router link.
module tb_ni_packetizer;
  import noc_pkg::*;

  localparam int CNT_W = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 req_valid, req_ready;
  addr_t                req_dst;
  logic [7:0]           req_len;
  logic                 data_valid, data_ready;
  logic [PAYLOAD_W-1:0] data;
  flit_t                up_flit;
  logic                 up_enable, up_ack;
  logic                 busy;
  logic [CNT_W-1:0]     pkt_cnt;

  always #5 clk = ~clk;

  ni_packetizer #(.X(1), .Y(1), .LEN_W(8), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dst    (req_dst),
    .req_len    (req_len),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data       (data),
    .up_flit    (up_flit),
    .up_enable  (up_enable),
    .up_ack     (up_ack),
    .busy       (busy),
    .pkt_cnt    (pkt_cnt)
  );

  typedef struct {
    addr_t      dst;
    logic [7:0] len;
  } desc_t;

  desc_t       desc_q[$];
  logic [31:0] data_q[$];
  flit_t       exp_q[$];
  int          tx_cyc[$];

  int n_vec   = 0;
  int n_err   = 0;
  int cyc     = 0;
  int exp_cnt = 0;
  bit cnt_chk   = 1'b0;
  bit dr_seen   = 1'b0;
  bit body_seen = 1'b0;
  bit mon_on    = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic flit_t hdr_flit(input addr_t d, input logic [7:0] l);
    flit_t f;
    f.flit_type = HEADER;
    // header layout: dst{x,y} | src{1,1} | len, right-aligned in the payload
    f.payload = {8'h00, d.x, d.y, 4'd1, 4'd1, l};
    return f;
  endfunction

  task automatic queue_pkt(input addr_t d, input int len);
    desc_t       e;
    flit_t       f;
    logic [31:0] w;
    e.dst = d;
    e.len = 8'(len);
    desc_q.push_back(e);
    exp_q.push_back(hdr_flit(d, 8'(len)));
    for (int i = 0; i < len; i++) begin
      w = $urandom;
      data_q.push_back(w);
      if (i == len - 1) f.flit_type = TAIL;
      else              f.flit_type = BODY;
      f.payload = w;
      exp_q.push_back(f);
    end
    if (len == 0) begin
      f.flit_type = TAIL;
      f.payload   = '0;
      exp_q.push_back(f);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !up_enable) begin
        step();
        return;
      end
    end
    chk("drain_timeout", 64'd0, 64'd1);
    step();
  endtask

  // driver + monitor: sample at negedge, drive 1 time unit after posedge
  initial begin : drive_mon
    bit    dhs, whs, tx;
    flit_t fe;
    forever begin
      @(negedge clk);
      cyc++;
      dhs = req_valid && req_ready;
      whs = data_valid && data_ready;
      tx  = up_enable && up_ack;
      if (data_ready) dr_seen = 1'b1;
      if (mon_on) begin
        if (cnt_chk) begin
          chk("pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt));
          cnt_chk = 1'b0;
        end
        if (tx) begin
          tx_cyc.push_back(cyc);
          if (up_flit.flit_type == BODY) body_seen = 1'b1;
          if (exp_q.size() == 0) chk("spurious_flit", 64'(up_flit), 64'd0);
          else begin
            fe = exp_q.pop_front();
            chk("flit", 64'(up_flit), 64'(fe));
            if (fe.flit_type == TAIL) begin
              exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
              cnt_chk = 1'b1;
            end
          end
        end
      end
      @(posedge clk);
      #1;
      if (dhs && desc_q.size() > 0) void'(desc_q.pop_front());
      if (whs && data_q.size() > 0) void'(data_q.pop_front());
      req_valid = desc_q.size() > 0;
      if (req_valid) begin
        req_dst = desc_q[0].dst;
        req_len = desc_q[0].len;
      end
      data_valid = data_q.size() > 0;
      if (data_valid) data = data_q[0];
    end
  end

  initial begin : main
    flit_t f0;
    up_ack = 1'b0; req_valid = 1'b0; data_valid = 1'b0;
    req_dst = '0; req_len = '0; data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_up_enable", 64'(up_enable), 64'd0);
    chk("rst_up_flit", 64'(up_flit), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_data_ready", 64'(data_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);

    step();
    rst = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);
    chk("release_req_ready_low", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("release_req_ready_high", 64'(req_ready), 64'd1);

    // basic packet, ack tied high
    step();
    up_ack = 1'b1;
    tx_cyc.delete();
    queue_pkt('{x: 4'd2, y: 4'd3}, 3);
    wait_drain(50);
    chk("basic_nflits", 64'(tx_cyc.size()), 64'd4);
    if (tx_cyc.size() == 4) chk("basic_span", 64'(tx_cyc[3] - tx_cyc[0]), 64'd3);

    // zero-length message
    dr_seen = 1'b0;
    tx_cyc.delete();
    queue_pkt('{x: 4'd5, y: 4'd6}, 0);
    wait_drain(50);
    chk("zero_nflits", 64'(tx_cyc.size()), 64'd2);
    chk("zero_data_ready", 64'(dr_seen), 64'd0);

    // backpressure on the header
    up_ack = 1'b0;
    queue_pkt('{x: 4'd7, y: 4'd1}, 2);
    f0 = hdr_flit('{x: 4'd7, y: 4'd1}, 8'd2);
    for (int i = 0; i < 20 && !up_enable; i++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_up_enable", 64'(up_enable), 64'd1);
      chk("bp_up_flit", 64'(up_flit), 64'(f0));
      chk("bp_data_ready", 64'(data_ready), 64'd0);
    end
    step();
    up_ack = 1'b1;
    wait_drain(50);

    // back-to-back single-word packets
    tx_cyc.delete();
    queue_pkt('{x: 4'd1, y: 4'd2}, 1);
    queue_pkt('{x: 4'd3, y: 4'd0}, 1);
    wait_drain(50);
    chk("b2b_nflits", 64'(tx_cyc.size()), 64'd4);
    if (tx_cyc.size() == 4) chk("b2b_span", 64'(tx_cyc[3] - tx_cyc[0]), 64'd3);
    @(negedge clk);
    chk("wrap_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // reset while a BODY flit is in flight
    step();
    body_seen = 1'b0;
    queue_pkt('{x: 4'd4, y: 4'd4}, 6);
    for (int i = 0; i < 30 && !body_seen; i++) @(posedge clk);
    chk("midrst_body_seen", 64'(body_seen), 64'd1);
    #2;
    rst = 1'b0;
    desc_q.delete(); data_q.delete(); exp_q.delete();
    exp_cnt = 0; cnt_chk = 1'b0;
    req_valid = 1'b0; data_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_up_enable", 64'(up_enable), 64'd0);
    chk("midrst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    repeat (10) @(negedge clk);
    chk("midrst_no_tail_cnt", 64'(pkt_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
